// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and helpers for the PISO serializer
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - parallel-in handshake and serial-out bundle
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             in_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  modport master (
    output in, in_valid,
    input  in_ready, sout, sout_valid, frame_start, frame_end, busy
  );

  modport slave (
    input  in, in_valid,
    output in_ready, sout, sout_valid, frame_start, frame_end, busy
  );
endinterface

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - loadable shift register presenting the next serial bit
module piso_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);
  logic [WIDTH-1:0] sr_q, sr_d;

  // load wins over shift so a back-to-back word replaces the drained one
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign bit_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - PISO serializer with frame markers and optional even parity
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0,
  parameter int PARITY_EN = 0
) (
  input logic                 clk,
  input logic                 clr,
  piso_serializer_if.slave    bus
);
  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam bit             PAR      = (PARITY_EN != 0);
  localparam bit             MSB      = (MSB_FIRST != 0);

  piso_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          par_q, par_d;
  logic          sout_q, sout_d;
  logic          valid_q, valid_d;
  logic          fs_q, fs_d;
  logic          fe_q, fe_d;
  logic          busy_q, busy_d;
  logic          in_ready;
  logic          accept;
  logic          shift_en;
  logic          cur_bit;

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB)
  ) u_shift (
    .clk     (clk),
    .clr     (clr),
    .load_i  (accept),
    .shift_i (shift_en),
    .data_i  (bus.in),
    .bit_o   (cur_bit)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT: begin
        if (cnt_q == '0) begin
          if (PAR)         state_d = PARITY;
          else if (accept) state_d = SHIFT;
          else             state_d = IDLE;
        end
      end
      PARITY:  state_d = accept ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready depends on state/counter only, so upstream never sees a comb loop through in_valid
  always_comb begin
    in_ready = (state_q == IDLE)
            || (state_q == SHIFT && cnt_q == '0 && !PAR)
            || (state_q == PARITY);
    accept   = bus.in_valid && in_ready && !clr;
    shift_en = (state_q == SHIFT);
    cnt_d    = cnt_q;
    par_d    = par_q;
    sout_d   = 1'b0;
    valid_d  = 1'b0;
    fs_d     = 1'b0;
    fe_d     = 1'b0;
    if (accept) begin
      cnt_d = CNT_LAST;
      par_d = ^bus.in;
    end else if (shift_en && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    case (state_q)
      SHIFT: begin
        sout_d  = cur_bit;
        valid_d = 1'b1;
        fs_d    = (cnt_q == CNT_LAST);
        fe_d    = (cnt_q == '0) && !PAR;
      end
      PARITY: begin
        sout_d  = par_q;
        valid_d = 1'b1;
        fe_d    = 1'b1;
      end
      default: ;
    endcase
    busy_d = valid_d;
  end

  assign bus.in_ready    = in_ready;
  assign bus.sout        = sout_q;
  assign bus.sout_valid  = valid_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_end   = fe_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench over LSB-first, MSB-first and parity variants
module tb_piso_serializer;
  typedef struct packed {
    logic b;
    logic s;
    logic e;
  } exp_t;

  logic       clk;
  logic       clr_a  [3];
  logic       vld_a  [3];
  logic [3:0] in_a   [3];
  logic [5:0] obs    [3];
  logic       mon_en [3];
  exp_t       exp_q  [3][$];
  int         n_cmp = 0;
  int         n_err = 0;

  piso_serializer_if #(.WIDTH(4)) if0 ();
  piso_serializer_if #(.WIDTH(4)) if1 ();
  piso_serializer_if #(.WIDTH(4)) if2 ();

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .PARITY_EN(0)) u0 (.clk(clk), .clr(clr_a[0]), .bus(if0));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .PARITY_EN(0)) u1 (.clk(clk), .clr(clr_a[1]), .bus(if1));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .PARITY_EN(1)) u2 (.clk(clk), .clr(clr_a[2]), .bus(if2));

  assign if0.in = in_a[0];
  assign if0.in_valid = vld_a[0];
  assign if1.in = in_a[1];
  assign if1.in_valid = vld_a[1];
  assign if2.in = in_a[2];
  assign if2.in_valid = vld_a[2];

  // {sout, sout_valid, frame_start, frame_end, busy, in_ready}
  assign obs[0] = {if0.sout, if0.sout_valid, if0.frame_start, if0.frame_end, if0.busy, if0.in_ready};
  assign obs[1] = {if1.sout, if1.sout_valid, if1.frame_start, if1.frame_end, if1.busy, if1.in_ready};
  assign obs[2] = {if2.sout, if2.sout_valid, if2.frame_start, if2.frame_end, if2.busy, if2.in_ready};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input int d, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endfunction

  // Reference: a frame is the word's bits in the configured order, optionally followed by even parity
  function automatic void push_frame(input int d, input logic [3:0] w);
    bit   msb = (d == 1);
    bit   par = (d == 2);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.b = msb ? w[3 - i] : w[i];
      e.s = (i == 0);
      e.e = (i == 3) && !par;
      exp_q[d].push_back(e);
    end
    if (par) begin
      e.b = ($countones(w) % 2) == 1;
      e.s = 1'b0;
      e.e = 1'b1;
      exp_q[d].push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (mon_en[d]) begin
        logic [5:0] o;
        exp_t       e;
        o = obs[d];
        if (o[4]) begin
          if (exp_q[d].size() == 0) begin
            chk("unexpected_bit", d, 1, 0);
          end else begin
            e = exp_q[d].pop_front();
            chk("bit_start_end", d, int'({o[5], o[3], o[2]}), int'({e.b, e.s, e.e}));
            chk("busy_in_frame", d, int'(o[1]), 1);
          end
        end else begin
          chk("idle_outputs", d, int'({o[5], o[3], o[2], o[1]}), 0);
        end
        chk("in_ready", d, int'(o[0]), int'(exp_q[d].size() <= 1));
      end
    end
  end

  task automatic send(input int d, input logic [3:0] w, input int gap, input int ab);
    int tmo = 0;
    vld_a[d] = 1'b1;
    in_a[d]  = w;
    while (!obs[d][0]) begin
      @(negedge clk);
      #1;
      tmo++;
      if (tmo > 50) break;
    end
    if (tmo > 50) begin
      chk("accept_timeout", d, 0, 1);
      vld_a[d] = 1'b0;
      return;
    end
    push_frame(d, w);
    @(negedge clk);
    #1;
    vld_a[d] = 1'b0;
    in_a[d]  = 4'($urandom);
    if (ab >= 0) begin
      repeat (ab) begin
        @(negedge clk);
        #1;
      end
      clr_a[d] = 1'b1;
      exp_q[d].delete();
      @(negedge clk);
      #1;
      clr_a[d] = 1'b0;
    end
    repeat (gap) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run(input int d);
    send(d, 4'b1011, 2, -1);
    send(d, 4'hA, 0, -1);
    send(d, 4'h5, 2, -1);
    send(d, 4'b0111, 2, -1);
    send(d, 4'hF, 0, 3);
    send(d, 4'h3, 2, -1);
    for (int i = 0; i < 40; i++) begin
      send(d, 4'($urandom), int'($urandom_range(0, 2)),
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      clr_a[d]  = 1'b1;
      vld_a[d]  = 1'b1;
      in_a[d]   = 4'hF;
      mon_en[d] = 1'b0;
    end
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) mon_en[d] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    for (int d = 0; d < 3; d++) begin
      clr_a[d] = 1'b0;
      vld_a[d] = 1'b0;
    end
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    fork
      run(0);
      run(1);
      run(2);
    join
    repeat (12) begin
      @(negedge clk);
      #1;
    end
    for (int d = 0; d < 3; d++) chk("drained", d, exp_q[d].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
